// File: rtl/nano_cpu_pkg.sv
// nano_cpu_pkg
// Shared definitions for the nano_cpu multicycle core: datapath widths, FSM
// state encodings, the opcode enumeration and the instruction field layout.
// No ports; imported by nano_cpu and nano_cpu_alu.

package nano_cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int NREG   = 16;
    localparam int RIDX_W = 4;

    // State codes kept as plain constants so external tools can decode state
    // values without knowing about the enum type.
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    typedef enum logic [1:0] {
        FETCH = ST_FETCH,
        EXEC  = ST_EXEC,
        HALT  = ST_HALT
    } state_t;

    // Opcodes 9..E are not listed: they decode as NOP.
    typedef enum logic [3:0] {
        OP_READ   = 4'h0,
        OP_JUMP   = 4'h1,
        OP_WRITE  = 4'h2,
        OP_BRANCH = 4'h3,
        OP_XOR    = 4'h4,
        OP_SUB    = 4'h5,
        OP_ADD    = 4'h6,
        OP_LESS   = 4'h7,
        OP_INC    = 4'h8,
        OP_END    = 4'hF
    } opcode_t;

    // op | t | a | b ; memory/branch target is {t, a}.
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] t;
        logic [3:0] a;
        logic [3:0] b;
    } instr_t;

endpackage

// File: rtl/nano_cpu_alu.sv
// nano_cpu_alu
// Combinational ALU for the register-to-register opcodes.
// Ports:
//   op_i     opcode of the instruction in EXEC
//   a_i      value of R[a]
//   b_i      value of R[b]
//   result_o 16-bit result (XOR, SUB, ADD, LESS, INC); zero for other opcodes

module nano_cpu_alu
    import nano_cpu_pkg::*;
(
    input  opcode_t           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_XOR:  result_o = a_i ^ b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_ADD:  result_o = a_i + b_i;
            // Unsigned compare, result is a 0/1 flag.
            OP_LESS: result_o = (a_i < b_i) ? 16'h0001 : 16'h0000;
            // INC works on R[b], which arrives on b_i.
            OP_INC:  result_o = b_i + 16'd1;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/nano_cpu.sv
// nano_cpu
// Minimal 16-bit multicycle CPU. Every instruction takes a FETCH cycle and an
// EXEC cycle; END parks the core in HALT until reset. Sits on a single memory
// port with combinational read and synchronous write.
// Ports:
//   ck       clock, all state updates on the rising edge
//   rst      synchronous active-high reset
//   address  memory address (PC on fetch, {t,a} on READ/WRITE)
//   dataR    memory read data, valid in the same cycle as address
//   dataW    memory write data, always R[b]
//   ce       memory access enable (fetch, READ, WRITE)
//   we       memory write enable (WRITE only)
// Memory handshake: there is no stall. The memory must return dataR in the
// cycle that address is presented with ce=1, and must commit dataW on the
// rising edge that ends a cycle with we=1.

module nano_cpu
    import nano_cpu_pkg::*;
(
    input  logic              ck,
    input  logic              rst,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] dataR,
    output logic [DATA_W-1:0] dataW,
    output logic              ce,
    output logic              we
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    instr_t              ir_q, ir_d;
    logic [DATA_W-1:0]   regs_q [NREG];

    logic                rf_we;
    logic [RIDX_W-1:0]   rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;

    opcode_t             op;
    logic [ADDR_W-1:0]   target;
    logic [DATA_W-1:0]   rs_a;
    logic [DATA_W-1:0]   rs_b;
    logic [DATA_W-1:0]   alu_res;

    assign op     = opcode_t'(ir_q.op);
    assign target = {ir_q.t, ir_q.a};
    // Both sources come from the current register contents, so an
    // instruction may name the same register as source and destination.
    assign rs_a   = regs_q[ir_q.a];
    assign rs_b   = regs_q[ir_q.b];
    assign dataW  = rs_b;

    nano_cpu_alu u_alu (
        .op_i     (op),
        .a_i      (rs_a),
        .b_i      (rs_b),
        .result_o (alu_res)
    );

    // Next-state and register-file write control.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        rf_we    = 1'b0;
        rf_waddr = ir_q.t;
        rf_wdata = alu_res;
        case (state_q)
            FETCH: begin
                ir_d    = instr_t'(dataR);
                pc_d    = pc_q + 8'd1;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                case (op)
                    OP_READ: begin
                        rf_we    = 1'b1;
                        rf_waddr = ir_q.b;
                        rf_wdata = dataR;
                    end
                    OP_JUMP:   pc_d = target;
                    OP_BRANCH: if (rs_b != '0) pc_d = target;
                    OP_XOR, OP_SUB, OP_ADD, OP_LESS: rf_we = 1'b1;
                    OP_INC: begin
                        rf_we    = 1'b1;
                        rf_waddr = ir_q.b;
                    end
                    OP_END:  state_d = HALT;
                    default: ;
                endcase
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Memory port: idle (address=PC) except on fetch and on READ/WRITE EXEC.
    // Reset forces the port fully quiet regardless of the current state.
    always_comb begin
        address = pc_q;
        ce      = 1'b0;
        we      = 1'b0;
        if (rst) begin
            address = '0;
        end else begin
            case (state_q)
                FETCH: ce = 1'b1;
                EXEC: begin
                    if (op == OP_READ) begin
                        address = target;
                        ce      = 1'b1;
                    end else if (op == OP_WRITE) begin
                        address = target;
                        ce      = 1'b1;
                        we      = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            if (rf_we) begin
                regs_q[rf_waddr] <= rf_wdata;
            end
        end
    end

endmodule

// File: tb/tb_nano_cpu.sv
`timescale 1ns/1ps
// tb_nano_cpu
// Bench for nano_cpu: behavioural 256x16 memory, an instruction-level ISA
// model, and lockstep checking of the memory port every cycle.

module tb_nano_cpu;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  address;
    logic [15:0] dataR;
    logic [15:0] dataW;
    logic        ce;
    logic        we;

    // Behavioural memory; images are loaded through the clocked process so
    // that only one process ever writes the array.
    logic [15:0] mem [256];
    logic [15:0] load_img [256];
    logic        load_now = 1'b0;

    // ISA-level reference model.
    logic [7:0]  m_pc;
    logic [15:0] m_r [16];
    logic [15:0] m_mem [256];
    bit          m_halted;

    int n_tests = 0;
    int n_fail  = 0;

    nano_cpu dut (
        .ck      (ck),
        .rst     (rst),
        .address (address),
        .dataR   (dataR),
        .dataW   (dataW),
        .ce      (ce),
        .we      (we)
    );

    always #1 ck = ~ck;

    assign dataR = mem[address];

    always @(posedge ck) begin
        if (load_now) begin
            for (int i = 0; i < 256; i++) mem[i] <= load_img[i];
        end else if (we) begin
            mem[address] <= dataW;
        end
    end

    task automatic tick();
        @(negedge ck);
        #0.1;
    endtask

    task automatic load_memory();
        for (int i = 0; i < 256; i++) m_mem[i] = load_img[i];
        load_now = 1'b1;
        @(posedge ck);
        #0.1;
        load_now = 1'b0;
    endtask

    task automatic fill_img(input logic [15:0] v);
        for (int i = 0; i < 256; i++) load_img[i] = v;
    endtask

    // Holds rst across one edge, checks the quiet port, then releases.
    task automatic apply_reset(input string tag);
        rst = 1'b1;
        @(posedge ck);
        tick();
        n_tests++;
        if ({address, ce, we} !== {8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s_reset_port: got addr=%h ce=%b we=%b, want addr=00 ce=0 we=0",
                     tag, address, ce, we);
        end
        rst = 1'b0;
        #0.1;
        m_pc = 8'h00;
        for (int i = 0; i < 16; i++) m_r[i] = 16'h0000;
        m_halted = 1'b0;
    endtask

    // One instruction (two cycles) in lockstep, or one cycle while halted.
    task automatic step_instr(input string tag);
        logic [15:0] ir;
        logic [3:0]  op, t, a, b;
        logic [7:0]  ad;
        logic [7:0]  e_addr;
        logic        e_ce, e_we;
        if (m_halted) begin
            n_tests++;
            if ({address, ce, we} !== {m_pc, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL %s_halt: got addr=%h ce=%b we=%b, want addr=%h ce=0 we=0",
                         tag, address, ce, we, m_pc);
            end
            tick();
            return;
        end
        // FETCH cycle
        n_tests++;
        if ({address, ce, we} !== {m_pc, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL %s_fetch: got addr=%h ce=%b we=%b, want addr=%h ce=1 we=0",
                     tag, address, ce, we, m_pc);
        end
        ir   = m_mem[m_pc];
        m_pc = m_pc + 8'd1;
        tick();
        // EXEC cycle
        op = ir[15:12];
        t  = ir[11:8];
        a  = ir[7:4];
        b  = ir[3:0];
        ad = ir[11:4];
        e_addr = m_pc;
        e_ce   = 1'b0;
        e_we   = 1'b0;
        if (op == 4'h0) begin
            e_addr = ad;
            e_ce   = 1'b1;
        end else if (op == 4'h2) begin
            e_addr = ad;
            e_ce   = 1'b1;
            e_we   = 1'b1;
        end
        n_tests++;
        if ({address, ce, we} !== {e_addr, e_ce, e_we}) begin
            n_fail++;
            $display("FAIL %s_exec ir=%h: got addr=%h ce=%b we=%b, want addr=%h ce=%b we=%b",
                     tag, ir, address, ce, we, e_addr, e_ce, e_we);
        end
        if (e_we) begin
            n_tests++;
            if (dataW !== m_r[b]) begin
                n_fail++;
                $display("FAIL %s_dataw ir=%h: got %h, want %h", tag, ir, dataW, m_r[b]);
            end
        end
        case (op)
            4'h0: m_r[b] = m_mem[ad];
            4'h1: m_pc = ad;
            4'h2: m_mem[ad] = m_r[b];
            4'h3: if (m_r[b] != 16'h0000) m_pc = ad;
            4'h4: m_r[t] = m_r[a] ^ m_r[b];
            4'h5: m_r[t] = m_r[a] - m_r[b];
            4'h6: m_r[t] = m_r[a] + m_r[b];
            4'h7: m_r[t] = (m_r[a] < m_r[b]) ? 16'h0001 : 16'h0000;
            4'h8: m_r[b] = m_r[b] + 16'h0001;
            4'hF: m_halted = 1'b1;
            default: ;
        endcase
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fill_img(16'h9000);
        load_memory();
        apply_reset("rst");
        n_tests++;
        if ({address, ce, we} !== {8'h00, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL first_fetch: got addr=%h ce=%b we=%b, want addr=00 ce=1 we=0",
                     address, ce, we);
        end
    endtask

    // Hand-written program covering every opcode, a taken branch, a
    // fall-through branch, then END, a long halt and a restart.
    task automatic test_program_and_halt();
        rst = 1'b1;
        fill_img(16'h9000);
        load_img[8'h00] = 16'h01E3;  // READ  R3 <= mem[1E]
        load_img[8'h01] = 16'h4111;  // XOR   R1 = R1^R1
        load_img[8'h02] = 16'h8011;  // INC   R1
        load_img[8'h03] = 16'h6012;  // ADD   R0 = R1+R2
        load_img[8'h04] = 16'h5001;  // SUB   R0 = R0-R1
        load_img[8'h05] = 16'h2123;  // WRITE mem[12] = R3
        load_img[8'h06] = 16'h8000;  // INC   R0
        load_img[8'h07] = 16'h8000;
        load_img[8'h08] = 16'h8000;  // R0 = 3
        load_img[8'h09] = 16'h1100;  // JUMP  10
        load_img[8'h0A] = 16'h7430;  // LESS  R4 = R3<R0 (10<3 -> 0)
        load_img[8'h0B] = 16'h30A4;  // BRANCH on R4=0 -> falls through
        load_img[8'h0C] = 16'h2144;  // WRITE mem[14] = R4
        load_img[8'h0D] = 16'hF000;  // END
        load_img[8'h10] = 16'h7403;  // LESS  R4 = R0<R3 (3<10 -> 1)
        load_img[8'h11] = 16'h30A4;  // BRANCH on R4=1 -> 0A
        load_img[8'h14] = 16'hBEEF;
        load_img[8'h1E] = 16'h000A;
        load_memory();
        apply_reset("prog");
        for (int i = 0; i < 20; i++) step_instr("prog");
        n_tests++;
        if (mem[8'h12] !== 16'h000A) begin
            n_fail++;
            $display("FAIL prog_mem12: got %h, want 000a", mem[8'h12]);
        end
        n_tests++;
        if (mem[8'h14] !== 16'h0000) begin
            n_fail++;
            $display("FAIL prog_mem14: got %h, want 0000", mem[8'h14]);
        end
        for (int i = 0; i < 50; i++) step_instr("halt");
        n_tests++;
        if ({address, ce, we} !== {8'h0E, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_pc: got addr=%h ce=%b we=%b, want addr=0e ce=0 we=0",
                     address, ce, we);
        end
        // Reset out of HALT restarts at address 0.
        apply_reset("halt_exit");
        n_tests++;
        if ({address, ce, we} !== {8'h00, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL restart_fetch: got addr=%h ce=%b we=%b, want addr=00 ce=1 we=0",
                     address, ce, we);
        end
        for (int i = 0; i < 4; i++) step_instr("restart");
    endtask

    // PC wraps FF -> 00.
    task automatic test_wrap();
        rst = 1'b1;
        fill_img(16'h9000);
        load_img[8'h00] = 16'h1FE0;  // JUMP  FE
        load_img[8'hFE] = 16'h8001;  // INC   R1
        load_img[8'hFF] = 16'h2011;  // WRITE mem[01] = R1
        load_memory();
        apply_reset("wrap");
        for (int i = 0; i < 8; i++) step_instr("wrap");
        n_tests++;
        if (mem[8'h01] !== 16'h0002) begin
            n_fail++;
            $display("FAIL wrap_mem01: got %h, want 0002", mem[8'h01]);
        end
    endtask

    // Random memory images executed back to back against the ISA model.
    task automatic test_random();
        logic [15:0] w;
        int          bad;
        for (int round = 0; round < 4; round++) begin
            rst = 1'b1;
            for (int i = 0; i < 256; i++) begin
                w = 16'($urandom);
                if (w[15:12] == 4'hF && $urandom_range(0, 7) != 0) w[15:12] = 4'h9;
                load_img[i] = w;
            end
            load_memory();
            apply_reset("rand");
            for (int i = 0; i < 300; i++) step_instr("rand");
            bad = 0;
            for (int i = 0; i < 256; i++) begin
                if (mem[i] !== m_mem[i]) bad++;
            end
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL rand_mem_image round %0d: got %0d differing words, want 0",
                         round, bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_program_and_halt();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
